// File: rtl/fa_seq_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder sequencer: FSM encodings,
// slice width and the index-width helper.
package fa_seq_ctrl_pkg;

    localparam int NIB = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A single-nibble build still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fa_seq_ctrl_fa4.sv
// fa_4bit: 4-bit ripple-carry adder slice shared by the sequencer, one
// full adder per bit.
module fa_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] so,
    output logic       co
);

    logic [4:0] w_c;

    assign w_c[0] = ci;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bit
            assign so[gi]    = a[gi] ^ b[gi] ^ w_c[gi];
            assign w_c[gi+1] = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign co = w_c[4];

endmodule

// File: rtl/fa_seq_ctrl.sv
// fa_seq_ctrl: adds two WIDTH-bit operands one nibble per clock through a
// single fa_4bit slice. Define FA_SEQ_SUB_EN to add the `sub` port (a - b).
module fa_seq_ctrl
    import fa_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef FA_SEQ_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int N     = WIDTH / NIB;
    localparam int IDX_W = idx_width(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_co;

    logic [NIB-1:0]   w_a_nibs [N];
    logic [NIB-1:0]   w_b_nibs [N];
    logic [NIB-1:0]   w_a_nib;
    logic [NIB-1:0]   w_b_nib;
    logic [NIB-1:0]   w_so;
    logic             w_slice_co;
    logic [WIDTH-1:0] w_work_next;
    logic [WIDTH-1:0] w_b_in;
    logic             w_ci_in;
    logic             w_last;

    // Subtraction is a + ~b + 1, folded into the operand capture.
`ifdef FA_SEQ_SUB_EN
    assign w_b_in  = sub ? ~b : b;
    assign w_ci_in = sub ? 1'b1 : ci;
`else
    assign w_b_in  = b;
    assign w_ci_in = ci;
`endif

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_nib
            assign w_a_nibs[gi] = r_a[gi*NIB +: NIB];
            assign w_b_nibs[gi] = r_b[gi*NIB +: NIB];
            assign w_work_next[gi*NIB +: NIB] =
                (r_idx == IDX_W'(gi)) ? w_so : r_work[gi*NIB +: NIB];
        end
    endgenerate

    assign w_a_nib = w_a_nibs[r_idx];
    assign w_b_nib = w_b_nibs[r_idx];
    assign w_last  = (r_idx == LAST_IDX);

    fa_4bit u_fa (
        .a  (w_a_nib),
        .b  (w_b_nib),
        .ci (r_carry),
        .so (w_so),
        .co (w_slice_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_RUN:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // The final edge takes the top nibble straight from the slice, so sum
    // and co only ever change when the whole result is ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_co    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= w_b_in;
                        r_carry <= w_ci_in;
                        r_idx   <= '0;
                        r_work  <= '0;
                    end
                end
                ST_RUN: begin
                    r_work  <= w_work_next;
                    r_carry <= w_slice_co;
                    if (w_last) begin
                        r_sum <= w_work_next;
                        r_co  <= w_slice_co;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum = r_sum;
    assign co  = r_co;

endmodule

// File: tb/tb_fa_seq_ctrl.sv
// Directed bench for fa_seq_ctrl (WIDTH=16); the subtract vectors run only
// when FA_SEQ_SUB_EN is defined.
module tb_fa_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
`ifdef FA_SEQ_SUB_EN
    logic        sub;
`endif
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        co;

    int n_tests = 0;
    int n_fail  = 0;

    fa_seq_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef FA_SEQ_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .co    (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called one step after an edge with the DUT in IDLE.
    task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_in,
                         input logic tci, input logic [15:0] es, input logic eco);
        int          n_cyc;
        int          n_busy;
        logic        held;
        logic [15:0] prev;
        prev  = sum;
        held  = 1'b1;
        a     = ta;
        b     = tb_in;
        ci    = tci;
        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        n_cyc  = 0;
        n_busy = 0;
        while (!done && n_cyc < 20) begin
            if (busy) n_busy++;
            if (sum !== prev) held = 1'b0;
            @(posedge clk); #1;
            n_cyc++;
        end
        $display("[TB] op %s a=0x%04h b=0x%04h ci=%0d -> sum=0x%04h co=%0d after %0d cycles",
                 tag, ta, tb_in, tci, sum, co, n_cyc);
        chk({tag, "_lat"},  32'(n_cyc), 32'd4);
        chk({tag, "_busy"}, 32'(n_busy), 32'd4);
        chk({tag, "_hold"}, 32'(held), 32'd1);
        chk({tag, "_sum"},  32'(sum), 32'(es));
        chk({tag, "_co"},   32'(co), 32'(eco));
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n_cyc;
        int n_pulse;
        int first_i;
        int last_i;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        ci    = 1'b0;
`ifdef FA_SEQ_SUB_EN
        sub   = 1'b0;
`endif
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(sum),  32'd0);
        chk("rst_co",   32'(co),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        do_op("add_2_5",    16'h0002, 16'h0005, 1'b0, 16'h0007, 1'b0);
        do_op("add_14_3",   16'h0014, 16'h0003, 1'b0, 16'h0017, 1'b0);
        do_op("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        do_op("add_0fff_c", 16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0);
        do_op("add_8000_c", 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1);

        // start held for 10 sampled edges: pulses after edges 5 and 11
        a = 16'h0001; b = 16'h0001; ci = 1'b0; start = 1'b1;
        n_pulse = 0; first_i = -1; last_i = -1;
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk); #1;
            if (i == 10) start = 1'b0;
            if (done) begin
                n_pulse++;
                if (first_i < 0) first_i = i;
                else last_i = i;
            end
        end
        $display("[TB] op held_start pulses=%0d first=%0d last=%0d sum=0x%04h",
                 n_pulse, first_i, last_i, sum);
        chk("held_pulses", 32'(n_pulse), 32'd2);
        chk("held_first",  32'(first_i), 32'd5);
        chk("held_gap",    32'(last_i - first_i), 32'd6);
        chk("held_sum",    32'(sum), 32'h0002);

        // operands and start changed during RUN must be ignored
        a = 16'h1234; b = 16'h1111; ci = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cyc = 1;
        while (!done && n_cyc < 20) begin
            @(posedge clk); #1;
            n_cyc++;
        end
        $display("[TB] op run_ignore a=0x1234 b=0x1111 -> sum=0x%04h co=%0d after %0d cycles",
                 sum, co, n_cyc);
        chk("ign_lat", 32'(n_cyc), 32'd4);
        chk("ign_sum", 32'(sum), 32'h2345);
        chk("ign_co",  32'(co), 32'd0);
        @(posedge clk); #1;

        // reset after two RUN edges aborts the operation
        a = 16'h00FF; b = 16'h0001; ci = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum",  32'(sum),  32'd0);
        chk("abort_co",   32'(co),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        n_pulse = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) n_pulse++;
        end
        $display("[TB] op abort done_after_reset=%0d", n_pulse);
        chk("abort_nodone", 32'(n_pulse), 32'd0);
        do_op("post_abort", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

`ifdef FA_SEQ_SUB_EN
        sub = 1'b1;
        do_op("sub_5_7", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
        do_op("sub_9_4", 16'h0009, 16'h0004, 1'b0, 16'h0005, 1'b1);
        sub = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
